// File: rtl/ring_mod_pkg.sv
// Shared types, constants and helpers for the ring-modulation sequencer.
// sat16 is only used when RING_MOD_SAT_EN is defined.
package ring_mod_pkg;

    localparam int LUT_AW    = 8;
    localparam int LUT_DEPTH = 1 << LUT_AW;
    localparam int CARRIER_W = 16;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MUL_L,
        MUL_R,
        OUT
    } state_t;

    // pi in Q48 fixed point, used to build the sine table at elaboration
    localparam logic signed [127:0] PI_Q48 = 128'sh3243F6A8885A3;

    function automatic sample_t sat16(input logic signed [31:0] value);
        if (value > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (value < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return value[15:0];
        end
    endfunction

    // round(32767*sin((2*idx+1)*pi/1024)) via a fixed-point Taylor series
    function automatic logic [CARRIER_W-1:0] quarter_sine(input int idx);
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        x    = (PI_Q48 * 128'(2 * idx + 1)) >>> 10;
        x2   = (x * x) >>> 48;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -(((term * x2) >>> 48) / 128'(2 * k * (2 * k + 1)));
            sum  = sum + term;
        end
        return CARRIER_W'((sum * 128'sd32767 + (128'sd1 <<< 47)) >>> 48);
    endfunction

endpackage

// File: rtl/ring_mod_sine_lut.sv
// Quarter-wave sine ROM with registered output; mirrors the address and
// negates the result according to the quadrant bits of the phase.
module ring_mod_sine_lut
    import ring_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [LUT_AW+1:0] phase_addr,
    output sample_t           carrier
);

    function automatic logic [LUT_DEPTH-1:0][CARRIER_W-1:0] build_rom();
        logic [LUT_DEPTH-1:0][CARRIER_W-1:0] table_v;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            table_v[i] = quarter_sine(i);
        end
        return table_v;
    endfunction

    localparam logic [LUT_DEPTH-1:0][CARRIER_W-1:0] ROM = build_rom();

    logic [1:0]        quadrant;
    logic [LUT_AW-1:0] addr;
    logic [LUT_AW-1:0] rom_idx;
    sample_t           magnitude;

    assign quadrant  = phase_addr[LUT_AW+1:LUT_AW];
    assign addr      = phase_addr[LUT_AW-1:0];
    // odd quadrants run the table backwards: 255-a is simply ~a
    assign rom_idx   = quadrant[0] ? ~addr : addr;
    assign magnitude = ROM[rom_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier <= '0;
        end else if (rd_en) begin
            carrier <= quadrant[1] ? -magnitude : magnitude;
        end
    end

endmodule

// File: rtl/ring_mod_sched.sv
// Ring-modulation sequencer: carrier oscillator plus one shared multiplier
// serving left then right. Define RING_MOD_SAT_EN to saturate instead of wrap.
module ring_mod_sched
    import ring_mod_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int SHIFT   = 15,
    parameter int DROP_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  sample_t            left_in,
    input  sample_t            right_in,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_clr,
    input  logic               disabled,
    output logic               out_valid,
    output sample_t            left_out,
    output sample_t            right_out,
    output logic [DROP_W-1:0]  drop_cnt
);

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic [LUT_AW+1:0]   lut_addr;
    sample_t             left_q;
    sample_t             right_q;
    logic                bypass;
    sample_t             carrier;
    logic                accept;
    sample_t             mul_sample;
    logic signed [31:0]  product;
    sample_t             mul_result;

    assign in_ready   = (state == IDLE) || (state == OUT);
    assign accept     = in_valid && in_ready;
    assign mul_sample = (state == MUL_R) ? right_q : left_q;
    assign product    = 32'(mul_sample) * 32'(carrier);

`ifdef RING_MOD_SAT_EN
    assign mul_result = sat16(product >>> SHIFT);
`else
    assign mul_result = sample_t'(product >>> SHIFT);
`endif

    ring_mod_sine_lut u_lut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (state == FETCH),
        .phase_addr (lut_addr),
        .carrier    (carrier)
    );

    // A clear coinciding with an accept still advances from zero, so the
    // accepted sample uses the old phase and the accumulator lands on phase_inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            lut_addr  <= '0;
            left_q    <= '0;
            right_q   <= '0;
            bypass    <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == OUT);
            if (accept) begin
                left_q   <= left_in;
                right_q  <= right_in;
                bypass   <= disabled;
                lut_addr <= phase[PHASE_W-1 -: LUT_AW+2];
                phase    <= (phase_clr ? {PHASE_W{1'b0}} : phase) + phase_inc;
            end else if (phase_clr) begin
                phase <= '0;
            end
            case (state)
                IDLE:    if (accept) state <= FETCH;
                FETCH:   state <= MUL_L;
                MUL_L: begin
                    left_out <= bypass ? left_q : mul_result;
                    state    <= MUL_R;
                end
                MUL_R: begin
                    right_out <= bypass ? right_q : mul_result;
                    state     <= OUT;
                end
                OUT:     state <= in_valid ? FETCH : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule
